macc_l2_cxu: RTL and testbench

- Stateful multiply-accumulate custom function unit with a CXU-L2 streaming request/response interface.
- Front stage is a 1:1 CXU selector that accepts the CXU id and routes only CXU 0 to the MAC datapath; all other ids get an error response.
- Holds one 32-bit accumulator plus a control-status word per state context.
- Sits between the CPU-side CXU interface and nothing downstream; it is a leaf accelerator.

---
 rtl/cxu_pkg.sv | 40 ++++
 rtl/macc_cxu_sel.sv | 20 ++
 rtl/macc_l2_cxu.sv | 165 ++++++++++++++++
 tb/tb_macc_l2_cxu.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cxu_pkg.sv
// Shared CXU definitions: response status codes, per-context control-status states,
// function ids and the status-word layout returned by READ_STATUS.
package cxu_pkg;

  typedef enum logic [2:0] {
    ST_OK        = 3'd0,
    ST_ERR_CXU   = 3'd1,
    ST_ERR_OP    = 3'd2,
    ST_ERR_STATE = 3'd3
  } status_e;

  typedef enum logic [1:0] {
    CS_OFF   = 2'd0,
    CS_INIT  = 2'd1,
    CS_CLEAN = 2'd2,
    CS_DIRTY = 2'd3
  } cs_e;

  localparam int unsigned FN_MULACC       = 0;
  localparam int unsigned FN_READ_STATUS  = 1023;
  localparam int unsigned FN_WRITE_STATUS = 1022;
  localparam int unsigned FN_READ_STATE   = 1021;
  localparam int unsigned FN_WRITE_STATE  = 1020;

  // Status word: size of the state context (in words) in bits 11:2, cs in bits 1:0.
  typedef struct packed {
    logic [19:0] rsvd;
    logic [9:0]  size;
    cs_e         cs;
  } status_word_t;

  function automatic status_word_t status_word(input cs_e cs);
    status_word_t w;
    w.rsvd = '0;
    w.size = 10'd1;
    w.cs   = cs;
    return w;
  endfunction

endpackage

// File: rtl/macc_cxu_sel.sv
// 1:1 CXU-id selector: only id 0 reaches the MAC datapath, every other id maps to ERR_CXU.
// Purely combinational; backpressure is handled by the top-level pipeline.
module macc_cxu_sel
  import cxu_pkg::*;
#(
  parameter int CXU_W = 1
) (
  input  logic             req_vld_i,
  input  logic [CXU_W-1:0] req_cxu_i,
  output logic             mac_vld_o,
  output status_e          err_status_o
);

  logic hit;

  assign hit          = (req_cxu_i == '0);
  assign mac_vld_o    = req_vld_i && hit;
  assign err_status_o = hit ? ST_OK : ST_ERR_CXU;

endmodule

// File: rtl/macc_l2_cxu.sv
// Stateful MAC CXU (L2 streaming): response CXU_LATENCY cycles after accept, whole pipe stalls on resp backpressure.
// Define MACC_L2_CXU_SATURATE_EN for signed saturating MULACC instead of unsigned wrap-around.
module macc_l2_cxu
  import cxu_pkg::*;
#(
  parameter  int N_CXUS      = 2,
  parameter  int N_STATES    = 1,
  parameter  int FUNC_ID_W   = 10,
  parameter  int DATA_W      = 32,
  parameter  int CXU_LATENCY = 1,
  localparam int CXU_W       = (N_CXUS > 1) ? $clog2(N_CXUS) : 1,
  localparam int ST_W        = (N_STATES > 1) ? $clog2(N_STATES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CXU_W-1:0]     req_cxu,
  input  logic [ST_W-1:0]      req_state,
  input  logic [FUNC_ID_W-1:0] req_func,
  input  logic [DATA_W-1:0]    req_data0,
  input  logic [DATA_W-1:0]    req_data1,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [2:0]           resp_status,
  output logic [DATA_W-1:0]    resp_data
);

  logic              adv, accept, mac_vld, state_ok;
  status_e           cxu_status, status_d;
  logic [ST_W-1:0]   sidx;
  logic [DATA_W-1:0] acc_cur, mac_sum, rdata_d, acc_d;
  cs_e               cs_cur, cs_d;
  logic              acc_we, cs_we;

  logic [DATA_W-1:0] acc_q [N_STATES];
  cs_e               cs_q  [N_STATES];
  logic              vld_q [CXU_LATENCY];
  status_e           stat_q[CXU_LATENCY];
  logic [DATA_W-1:0] dat_q [CXU_LATENCY];

  assign adv         = !(resp_valid && !resp_ready);
  assign req_ready   = adv;
  assign accept      = req_valid && adv;
  assign resp_valid  = vld_q[CXU_LATENCY-1];
  assign resp_status = stat_q[CXU_LATENCY-1];
  assign resp_data   = dat_q[CXU_LATENCY-1];

  macc_cxu_sel #(.CXU_W(CXU_W)) u_sel (
    .req_vld_i   (req_valid),
    .req_cxu_i   (req_cxu),
    .mac_vld_o   (mac_vld),
    .err_status_o(cxu_status)
  );

  always_comb begin
    state_ok = 32'(req_state) < N_STATES;
    sidx     = state_ok ? req_state : '0;
    acc_cur  = '0;
    cs_cur   = CS_OFF;
    for (int s = 0; s < N_STATES; s++) begin
      if (sidx == ST_W'(s)) begin
        acc_cur = acc_q[s];
        cs_cur  = cs_q[s];
      end
    end
  end

`ifdef MACC_L2_CXU_SATURATE_EN
  localparam logic signed [2*DATA_W:0] SAT_MAX = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W:0] SAT_MIN = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [2*DATA_W:0] a_x, b_x, c_x, wide;

  always_comb begin
    a_x  = {{(DATA_W+1){req_data0[DATA_W-1]}}, req_data0};
    b_x  = {{(DATA_W+1){req_data1[DATA_W-1]}}, req_data1};
    c_x  = {{(DATA_W+1){acc_cur[DATA_W-1]}}, acc_cur};
    wide = a_x * b_x + c_x;
    if (wide > SAT_MAX)      mac_sum = SAT_MAX[DATA_W-1:0];
    else if (wide < SAT_MIN) mac_sum = SAT_MIN[DATA_W-1:0];
    else                     mac_sum = wide[DATA_W-1:0];
  end
`else
  assign mac_sum = acc_cur + req_data0 * req_data1;
`endif

  // Errors leave every write-enable low, so they never touch acc/cs.
  always_comb begin
    status_d = ST_OK;
    rdata_d  = '0;
    acc_we   = 1'b0;
    acc_d    = '0;
    cs_we    = 1'b0;
    cs_d     = cs_cur;
    if (!mac_vld) begin
      status_d = cxu_status;
    end else if (!state_ok) begin
      status_d = ST_ERR_STATE;
    end else begin
      case (req_func)
        FUNC_ID_W'(FN_MULACC): begin
          acc_we  = 1'b1;
          acc_d   = mac_sum;
          cs_we   = 1'b1;
          cs_d    = CS_DIRTY;
          rdata_d = mac_sum;
        end
        FUNC_ID_W'(FN_READ_STATUS): rdata_d = DATA_W'(status_word(cs_cur));
        FUNC_ID_W'(FN_WRITE_STATUS): begin
          cs_we = 1'b1;
          if (cs_e'(req_data0[1:0]) == CS_INIT) begin
            acc_we = 1'b1;
            cs_d   = CS_CLEAN;
          end else begin
            cs_d = cs_e'(req_data0[1:0]);
          end
        end
        FUNC_ID_W'(FN_READ_STATE): rdata_d = acc_cur;
        FUNC_ID_W'(FN_WRITE_STATE): begin
          acc_we = 1'b1;
          acc_d  = req_data0;
          cs_we  = 1'b1;
          cs_d   = CS_DIRTY;
        end
        default: status_d = ST_ERR_OP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < N_STATES; s++) begin
        acc_q[s] <= '0;
        cs_q[s]  <= CS_INIT;
      end
    end else if (accept) begin
      for (int s = 0; s < N_STATES; s++) begin
        if (sidx == ST_W'(s)) begin
          if (acc_we) acc_q[s] <= acc_d;
          if (cs_we)  cs_q[s]  <= cs_d;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CXU_LATENCY; i++) begin
        vld_q[i]  <= 1'b0;
        stat_q[i] <= ST_OK;
        dat_q[i]  <= '0;
      end
    end else if (adv) begin
      vld_q[0]  <= accept;
      stat_q[0] <= accept ? status_d : ST_OK;
      dat_q[0]  <= accept ? rdata_d : '0;
      for (int i = 1; i < CXU_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        stat_q[i] <= stat_q[i-1];
        dat_q[i]  <= dat_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_macc_l2_cxu.sv
// Self-checking bench for macc_l2_cxu: directed table, stall/reset sequences, randomized stream vs a behavioural model.
module tb_macc_l2_cxu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [0:0]  req_cxu, req_state;
  logic [9:0]  req_func;
  logic [31:0] req_data0, req_data1;
  logic        resp_valid, resp_ready;
  logic [2:0]  resp_status;
  logic [31:0] resp_data;

  always #5 clk = ~clk;

  macc_l2_cxu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cxu(req_cxu), .req_state(req_state),
    .req_func(req_func), .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status), .resp_data(resp_data)
  );

  typedef struct {
    logic        cxu;
    logic        st;
    logic [9:0]  func;
    logic [31:0] d0;
    logic [31:0] d1;
  } req_t;

  typedef struct {
    logic [2:0]  status;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    req_t r;
    rsp_t e;
  } vec_t;

  int tests = 0;
  int fails = 0;
  req_t rq[$];
  rsp_t ex[$];
  vec_t tbl[$];

  logic [31:0] m_acc;
  logic [1:0]  m_cs;

  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -64'sd2147483648;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic cxu, input logic st, input logic [9:0] f,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] es, input logic [31:0] ed);
    vec_t v;
    v.r.cxu = cxu; v.r.st = st; v.r.func = f; v.r.d0 = a; v.r.d1 = b;
    v.e.status = es; v.e.data = ed;
    return v;
  endfunction

  // Reference model: the architectural effect of one request, in request order.
  function automatic rsp_t model_apply(input req_t r);
    rsp_t   e;
    longint p;
    e.status = 3'd0;
    e.data   = 32'd0;
    if (r.cxu != 1'b0) e.status = 3'd1;
    else if (r.st != 1'b0) e.status = 3'd3;
    else begin
      case (r.func)
        10'd0: begin
`ifdef MACC_L2_CXU_SATURATE_EN
          p = longint'($signed(r.d0)) * longint'($signed(r.d1)) + longint'($signed(m_acc));
          if (p > LMAX)      m_acc = 32'h7FFF_FFFF;
          else if (p < LMIN) m_acc = 32'h8000_0000;
          else               m_acc = p[31:0];
`else
          p = 0;
          m_acc = m_acc + r.d0 * r.d1;
`endif
          m_cs   = 2'd3;
          e.data = m_acc;
        end
        10'd1023: e.data = 32'd4 + {30'd0, m_cs};
        10'd1022: begin
          if (r.d0[1:0] == 2'd1) begin m_acc = 0; m_cs = 2'd2; end
          else m_cs = r.d0[1:0];
        end
        10'd1021: e.data = m_acc;
        10'd1020: begin m_acc = r.d0; m_cs = 2'd3; end
        default:  e.status = 3'd2;
      endcase
    end
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_acc = 0;
    m_cs  = 2'd1;
    @(posedge clk);
    #1;
  endtask

  // Drives rq[] and checks responses against ex[]; inputs change #1 after posedge, outputs sampled at negedge.
  task automatic run_stream(input int valid_pct, input int ready_pct,
                            input int hold_start, input int hold_len, output int cycles);
    int   n, sent, got, cyc;
    bit   pending, accepted, stalled;
    logic [31:0] sdat;
    logic [2:0]  sst;
    n = rq.size(); sent = 0; got = 0; cyc = 0;
    pending = 0; stalled = 0; sdat = 0; sst = 0;
    while (got < n && cyc < 5000) begin
      if (!pending && sent < n && $urandom_range(99) < valid_pct) pending = 1;
      req_valid = pending;
      if (pending) begin
        req_cxu = rq[sent].cxu; req_state = rq[sent].st; req_func = rq[sent].func;
        req_data0 = rq[sent].d0; req_data1 = rq[sent].d1;
      end
      if (cyc >= hold_start && cyc < hold_start + hold_len) resp_ready = 1'b0;
      else resp_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (stalled) begin
        chk("held_valid", {31'd0, resp_valid}, 32'd1);
        chk("held_data", resp_data, sdat);
        chk("held_status", {29'd0, resp_status}, {29'd0, sst});
      end
      chk("req_ready_rule", {31'd0, req_ready}, {31'd0, !(resp_valid && !resp_ready)});
      accepted = req_valid && req_ready;
      if (resp_valid && resp_ready) begin
        if (got < n) begin
          chk($sformatf("rsp%0d_status", got), {29'd0, resp_status}, {29'd0, ex[got].status});
          chk($sformatf("rsp%0d_data", got), resp_data, ex[got].data);
        end
        got++;
      end
      stalled = resp_valid && !resp_ready;
      sdat = resp_data;
      sst  = resp_status;
      @(posedge clk);
      #1;
      if (accepted) begin sent++; pending = 0; end
      cyc++;
    end
    if (got < n) chk("stream_timeout_responses", got, n);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    cycles = cyc;
    rq.delete();
    ex.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc, n;
    req_t r;
    req_valid = 0; req_cxu = 0; req_state = 0; req_func = 0;
    req_data0 = 0; req_data1 = 0; resp_ready = 1; rst_n = 0;

    tbl.push_back(mk(0, 0, 10'd1021, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 10'd1023, 0, 0, 0, 32'h5));
    tbl.push_back(mk(0, 0, 10'd0, 3, 4, 0, 12));
    tbl.push_back(mk(0, 0, 10'd0, 5, 6, 0, 42));
    tbl.push_back(mk(0, 0, 10'd1023, 0, 0, 0, 32'h7));
    tbl.push_back(mk(1, 0, 10'd0, 2, 2, 1, 0));
    tbl.push_back(mk(0, 0, 10'd1021, 0, 0, 0, 42));
    tbl.push_back(mk(0, 0, 10'd7, 1, 1, 2, 0));
    tbl.push_back(mk(0, 1, 10'd0, 1, 1, 3, 0));
`ifdef MACC_L2_CXU_SATURATE_EN
    tbl.push_back(mk(0, 0, 10'd1020, 32'h7FFF_FFFF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 10'd0, 1, 1, 0, 32'h7FFF_FFFF));
`else
    tbl.push_back(mk(0, 0, 10'd1020, 32'hFFFF_FFFF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 10'd0, 1, 1, 0, 0));
`endif
    tbl.push_back(mk(0, 0, 10'd0, 2, 5, 0, 10 + 0));
`ifdef MACC_L2_CXU_SATURATE_EN
    tbl[tbl.size()-1].e.data = 32'h7FFF_FFFF;
`endif
    tbl.push_back(mk(0, 0, 10'd1022, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 10'd1021, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 10'd1023, 0, 0, 0, 32'h6));
    tbl.push_back(mk(0, 0, 10'd1022, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 10'd1023, 0, 0, 0, 32'h7));

    // Reset values while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_resp_valid", {31'd0, resp_valid}, 0);
    chk("reset_resp_status", {29'd0, resp_status}, 0);
    chk("reset_resp_data", resp_data, 0);
    chk("reset_req_ready", {31'd0, req_ready}, 1);
    do_reset();

    // Directed table, back to back at full rate.
    for (int i = 0; i < tbl.size(); i++) begin
      rq.push_back(tbl[i].r);
      ex.push_back(tbl[i].e);
    end
    n = tbl.size();
    run_stream(100, 100, 0, 0, cyc);
    chk("table_full_rate_cycles", cyc, n + 1);

    // Three MULACCs with the response side held off for 3 cycles.
    r = '{cxu: 0, st: 0, func: 10'd1020, d0: 0, d1: 0};      rq.push_back(r); ex.push_back('{3'd0, 32'd0});
    r = '{cxu: 0, st: 0, func: 10'd0, d0: 2, d1: 3};         rq.push_back(r); ex.push_back('{3'd0, 32'd6});
    r = '{cxu: 0, st: 0, func: 10'd0, d0: 4, d1: 5};         rq.push_back(r); ex.push_back('{3'd0, 32'd26});
    r = '{cxu: 0, st: 0, func: 10'd0, d0: 1, d1: 7};         rq.push_back(r); ex.push_back('{3'd0, 32'd33});
    run_stream(100, 100, 2, 3, cyc);
    chk("stall_cycles", cyc, 4 + 1 + 3);

    // Randomized stream against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r.cxu = ($urandom_range(9) == 0);
      r.st  = ($urandom_range(9) == 0);
      case ($urandom_range(7))
        0, 1, 2: r.func = 10'd0;
        3:       r.func = 10'd1023;
        4:       r.func = 10'd1022;
        5:       r.func = 10'd1021;
        6:       r.func = 10'd1020;
        default: r.func = 10'($urandom_range(1019, 1));
      endcase
      if ($urandom_range(1) == 0) begin
        r.d0 = $urandom_range(65535); r.d1 = $urandom_range(65535);
      end else begin
        r.d0 = $urandom; r.d1 = $urandom;
      end
      rq.push_back(r);
      ex.push_back(model_apply(r));
    end
    run_stream(70, 70, 0, 0, cyc);

    // Reset asserted while a response is waiting.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_cxu = 0; req_state = 0; req_func = 10'd0; req_data0 = 9; req_data1 = 9;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("pre_reset_resp_valid", {31'd0, resp_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_resp_valid", {31'd0, resp_valid}, 0);
    chk("midreset_resp_data", resp_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    r = '{cxu: 0, st: 0, func: 10'd1021, d0: 0, d1: 0}; rq.push_back(r); ex.push_back('{3'd0, 32'd0});
    r = '{cxu: 0, st: 0, func: 10'd1023, d0: 0, d1: 0}; rq.push_back(r); ex.push_back('{3'd0, 32'h5});
    run_stream(100, 100, 0, 0, cyc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
